// File: rtl/ppt_fire_sequencer.sv
// PPT discharge sequencer: turns each rising edge of fire_req into
// CHARGE -> DEAD -> IGNITE -> HOLDOFF, with charge timeout, fault latch and shot counters.
module ppt_fire_sequencer #(
  parameter int CNT_W          = 14,
  parameter int DEAD_CYCLES    = 4,
  parameter int IGN_CYCLES     = 8,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fire_req,
  input  logic             cap_ready,
  input  logic [CNT_W-1:0] charge_timeout,
  input  logic             fault_clr,
  output logic             charge_en,
  output logic             ignite,
  output logic             busy,
  output logic             fault,
  output logic [7:0]       fire_count,
  output logic [7:0]       missed_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHARGE  = 3'd1,
    S_DEAD    = 3'd2,
    S_IGNITE  = 3'd3,
    S_HOLDOFF = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IGN_LAST     = CNT_W'(IGN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       fire_count_q, fire_count_d;
  logic [7:0]       missed_count_q, missed_count_d;
  logic             cap_meta_q, cap_s_q;
  logic             fire_req_q;
  logic             req_edge;
  logic             timeout_hit;
  logic             active;

  // State register, cap_ready synchronizer, fire_req edge detector and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      fire_count_q   <= 8'd0;
      missed_count_q <= 8'd0;
      cap_meta_q     <= 1'b0;
      cap_s_q        <= 1'b0;
      fire_req_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      fire_count_q   <= fire_count_d;
      missed_count_q <= missed_count_d;
      cap_meta_q     <= cap_ready;
      cap_s_q        <= cap_meta_q;
      fire_req_q     <= fire_req;
    end
  end

  assign req_edge = fire_req & ~fire_req_q;
  // A zero timeout behaves like a one-cycle charge window rather than wrapping the timer.
  assign timeout_hit = (charge_timeout == '0) || (timer_q == (charge_timeout - ONE));
  assign active = (state_q == S_CHARGE) || (state_q == S_DEAD) ||
                  (state_q == S_IGNITE) || (state_q == S_HOLDOFF);

  always_comb begin
    state_d = state_q;
    if (active && !enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (req_edge && enable) state_d = S_CHARGE;
        S_CHARGE: begin
          if (cap_s_q)          state_d = S_DEAD;
          else if (timeout_hit) state_d = S_FAULT;
        end
        S_DEAD:    if (timer_q == DEAD_LAST)    state_d = S_IGNITE;
        S_IGNITE:  if (timer_q == IGN_LAST)     state_d = S_HOLDOFF;
        S_HOLDOFF: if (timer_q == HOLDOFF_LAST) state_d = S_IDLE;
        S_FAULT:   if (fault_clr)               state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    timer_d = (state_d != state_q) ? '0 : (active ? timer_q + ONE : '0);

    fire_count_d = fire_count_q;
    if (state_q == S_IGNITE && state_d == S_HOLDOFF) fire_count_d = fire_count_q + 8'd1;

    missed_count_d = missed_count_q;
    if (req_edge && (state_q != S_IDLE || !enable) && missed_count_q != 8'hFF)
      missed_count_d = missed_count_q + 8'd1;
  end

  // Moore outputs; the one-hot decode keeps charge_en and ignite mutually exclusive.
  always_comb begin
    charge_en = (state_q == S_CHARGE);
    ignite    = (state_q == S_IGNITE);
    fault     = (state_q == S_FAULT);
    busy      = (state_q != S_IDLE);
  end

  assign fire_count   = fire_count_q;
  assign missed_count = missed_count_q;

endmodule

// File: tb/tb_ppt_fire_sequencer.sv
// Self-checking bench for ppt_fire_sequencer: phase-level reference model feeding a
// per-cycle scoreboard, plus directed scenario checks against fixed timelines.
module tb_ppt_fire_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fire_req = 1'b0;
  logic        cap_ready = 1'b0;
  logic [13:0] charge_timeout = 14'd100;
  logic        fault_clr = 1'b0;
  logic        charge_en, ignite, busy, fault;
  logic [7:0]  fire_count, missed_count;

  int n_tests = 0;
  int n_fail  = 0;

  ppt_fire_sequencer #(
    .CNT_W(14), .DEAD_CYCLES(4), .IGN_CYCLES(8), .HOLDOFF_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fire_req(fire_req),
    .cap_ready(cap_ready), .charge_timeout(charge_timeout), .fault_clr(fault_clr),
    .charge_en(charge_en), .ignite(ignite), .busy(busy), .fault(fault),
    .fire_count(fire_count), .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (phase + cycles-left view) ----------------
  typedef enum int {M_IDLE, M_CHARGE, M_DEAD, M_IGNITE, M_HOLDOFF, M_FAULT} mode_t;
  mode_t       mode = M_IDLE;
  int          left = 0;
  int          n_charge = 0;
  int          fires = 0;
  int          missed = 0;
  bit          prev_req = 1'b0;
  bit          c1 = 1'b0;
  bit          c2 = 1'b0;
  logic [19:0] exp_q[$];

  task automatic model_reset();
    mode = M_IDLE; left = 0; n_charge = 0; fires = 0; missed = 0;
    prev_req = 1'b0; c1 = 1'b0; c2 = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit e, cap_s;
    int limit;
    e = fire_req && !prev_req;
    prev_req = fire_req;
    cap_s = c2;
    c2 = c1;
    c1 = cap_ready;
    limit = (charge_timeout == 0) ? 1 : int'(charge_timeout);
    if (e && (mode != M_IDLE || !enable)) missed = (missed < 255) ? missed + 1 : 255;
    if (!enable && (mode == M_CHARGE || mode == M_DEAD || mode == M_IGNITE || mode == M_HOLDOFF)) begin
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE: if (e && enable) begin mode = M_CHARGE; n_charge = 1; end
        M_CHARGE: begin
          if (cap_s) begin mode = M_DEAD; left = 4; end
          else if (n_charge == limit) mode = M_FAULT;
          else n_charge++;
        end
        M_DEAD: begin left--; if (left == 0) begin mode = M_IGNITE; left = 8; end end
        M_IGNITE: begin
          left--;
          if (left == 0) begin mode = M_HOLDOFF; left = 16; fires = (fires + 1) % 256; end
        end
        M_HOLDOFF: begin left--; if (left == 0) mode = M_IDLE; end
        M_FAULT: if (fault_clr) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
    exp_q.push_back({mode == M_CHARGE, mode == M_IGNITE, mode != M_IDLE, mode == M_FAULT,
                     8'(fires), 8'(missed)});
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_cycle();
    logic [19:0] exp_v, act_v;
    if (rst_n && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {charge_en, ignite, busy, fault, fire_count, missed_count};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t actual{ch,ig,busy,flt,fc,mc}=%h required=%h",
                 $time, act_v, exp_v);
      end
      n_tests++;
      if (charge_en && ignite) begin
        n_fail++;
        $display("FAIL interlock t=%0t actual charge_en=1 ignite=1 required not both", $time);
      end
    end
  endtask

  always @(negedge clk) monitor_cycle();

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic toggle_edge();
    fire_req = 1'b0; tick();
    fire_req = 1'b1; tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ch_first, ch_n, dead_n, ig_first, ig_n, busy_last, fault_seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {charge_en, ignite, busy, fault}, 0);
    check("reset_counters", {fire_count, missed_count}, 0);
    #1 rst_n = 1'b1;
    tick();

    // Nominal shot, timeout=100, cap_ready from cycle 5.
    enable = 1'b1; charge_timeout = 14'd100; tick(); tick();
    ch_first = -1; ch_n = 0; dead_n = 0; ig_first = -1; ig_n = 0; busy_last = -1;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) fire_req = 1'b1;
      if (c == 5) cap_ready = 1'b1;
      @(negedge clk);
      if (charge_en) begin if (ch_first < 0) ch_first = c; ch_n++; end
      if (busy && !charge_en && !ignite && ch_first >= 0 && ig_first < 0) dead_n++;
      if (ignite) begin if (ig_first < 0) ig_first = c; ig_n++; end
      if (busy) busy_last = c;
      tick();
    end
    check("nom_charge_first", ch_first, 1);
    check("nom_charge_len", ch_n, 7);
    check("nom_dead_len", dead_n, 4);
    check("nom_ignite_first", ig_first, 12);
    check("nom_ignite_len", ig_n, 8);
    check("nom_busy_last", busy_last, 35);
    check("nom_fire_count", fire_count, 1);
    check("nom_missed_count", missed_count, 0);
    $display("[TB] nominal shot: charge %0d cycles, ignite %0d cycles", ch_n, ig_n);

    // Charge timeout with cap_ready held low.
    cap_ready = 1'b0; fire_req = 1'b0; charge_timeout = 14'd10;
    repeat (3) tick();
    ch_n = 0;
    for (int c = 0; c < 31; c++) begin
      if (c == 0) fire_req = 1'b1;
      @(negedge clk);
      if (charge_en) ch_n++;
      tick();
    end
    check("to_charge_len", ch_n, 10);
    check("to_fault_held", fault, 1);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    @(negedge clk);
    check("to_fault_cleared", {fault, busy}, 0);
    check("to_fire_count", fire_count, 1);
    $display("[TB] timeout: charge %0d cycles then fault, cleared", ch_n);

    // Race: cap_s rises on the last allowed charge cycle.
    fire_req = 1'b0; tick();
    ch_n = 0; fault_seen = 0; busy_last = -1;
    for (int c = 0; c < 42; c++) begin
      if (c == 0) fire_req = 1'b1;
      if (c == 8) cap_ready = 1'b1;
      @(negedge clk);
      if (charge_en) ch_n++;
      if (fault) fault_seen = 1;
      if (busy) busy_last = c;
      tick();
    end
    check("race_charge_len", ch_n, 10);
    check("race_no_fault", fault_seen, 0);
    check("race_busy_last", busy_last, 38);
    check("race_fire_count", fire_count, 2);
    $display("[TB] race: cap vs timeout, fault_seen=%0d", fault_seen);

    // Abort during IGNITE, then a fresh shot.
    cap_ready = 1'b0; fire_req = 1'b0; repeat (3) tick();
    fire_req = 1'b1; cap_ready = 1'b1;
    repeat (9) tick();
    @(negedge clk);
    check("abort_ignite_before", ignite, 1);
    enable = 1'b0; tick();
    @(negedge clk);
    check("abort_ignite_after", {ignite, busy}, 0);
    check("abort_fire_count", fire_count, 2);
    enable = 1'b1; fire_req = 1'b0; tick();
    fire_req = 1'b1; tick();
    @(negedge clk);
    check("abort_restart_charge", charge_en, 1);
    repeat (40) tick();
    check("abort_restart_fired", fire_count, 3);
    $display("[TB] abort: ignite dropped, restart fired");

    // Three edges during HOLDOFF.
    fire_req = 1'b0; tick();
    fire_req = 1'b1; repeat (15) tick();
    repeat (3) toggle_edge();
    repeat (20) tick();
    check("holdoff_missed", missed_count, 3);
    check("holdoff_fire_count", fire_count, 4);
    $display("[TB] holdoff: missed_count=%0d", missed_count);

    // 300 edges while disabled saturate the missed counter.
    enable = 1'b0;
    repeat (300) toggle_edge();
    check("missed_saturate", missed_count, 255);
    $display("[TB] saturation: missed_count=%0d", missed_count);
    fire_req = 1'b0;

    // Randomized segments; timeout only changes while the sequencer is forced idle.
    for (int s = 0; s < 8; s++) begin
      enable = 1'b0; tick();
      charge_timeout = (s == 0) ? 14'd0 : (s == 1) ? 14'd1 : 14'($urandom_range(2, 14));
      for (int c = 0; c < 250; c++) begin
        enable    = ($urandom_range(0, 29) != 0);
        if ($urandom_range(0, 4) == 0) fire_req = ~fire_req;
        if ($urandom_range(0, 9) < 2)  cap_ready = ~cap_ready;
        fault_clr = ($urandom_range(0, 19) == 0);
        tick();
      end
      fault_clr = 1'b0;
      $display("[TB] random segment %0d: timeout=%0d fires=%0d", s, charge_timeout, fire_count);
    end

    // Async reset asserted mid-CHARGE.
    enable = 1'b0; fault_clr = 1'b1; cap_ready = 1'b0; fire_req = 1'b0; charge_timeout = 14'd100;
    repeat (3) tick();
    fault_clr = 1'b0; enable = 1'b1; tick();
    fire_req = 1'b1; tick(); tick();
    @(negedge clk);
    check("rst_pre_charge", charge_en, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {charge_en, ignite, busy, fault}, 0);
    check("rst_async_counters", {fire_count, missed_count}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) tick();
    $display("[TB] async reset mid-charge done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
